// File: rtl/tree_accum_ctrl.sv
// Sequencer/accumulator behind the 8-register pipelined bf16 adder tree: credit-based beat admission,
// tag tracking through the tree latency, dot-product accumulation and a result FIFO. Optional stats: TREE_ACC_STATS_EN.
module tree_accum_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TREE_LAT   = 8,
  parameter int CHUNK_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] tree_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CHUNK_W-1:0]    out_chunks,
  output logic                  busy
`ifdef TREE_ACC_STATS_EN
  ,
  output logic [31:0]           stat_dots,
  output logic [31:0]           stat_stalls
`else
  // statistics ports are absent in the default build
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(TREE_LAT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + TREE_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  // bf16 add, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [7:0]  d;
    logic [21:0] aligned;
    logic [11:0] big_x, sml_x, r;
    logic        sticky, rnd;
    logic [8:0]  mant;
    int          e, p;
    if (a[14:7] == 8'hFF || b[14:7] == 8'hFF) begin
      if ((a[14:7] == 8'hFF && a[6:0] != 7'd0) || (b[14:7] == 8'hFF && b[6:0] != 7'd0) ||
          (a[14:7] == 8'hFF && b[14:7] == 8'hFF && a[15] != b[15]))
        return 16'h7FC0;
      return (a[14:7] == 8'hFF) ? a : b;
    end
    if (a[14:7] == 8'd0) return (b[14:7] == 8'd0) ? 16'h0000 : b;
    if (b[14:7] == 8'd0) return a;
    big     = (a[14:0] >= b[14:0]) ? a : b;
    sml     = (a[14:0] >= b[14:0]) ? b : a;
    d       = big[14:7] - sml[14:7];
    aligned = {1'b1, sml[6:0], 14'b0} >> ((d > 8'd12) ? 8'd12 : d);
    sticky  = |aligned[10:0];
    big_x   = {2'b01, big[6:0], 3'b000};
    sml_x   = {1'b0, aligned[21:12], aligned[11] | sticky};
    r       = (a[15] == b[15]) ? big_x + sml_x : big_x - sml_x;
    if (r == 12'd0) return 16'h0000;
    e = int'(big[14:7]);
    if (r[11]) begin
      r = {1'b0, r[11:2], r[1] | r[0]};
      e = e + 1;
    end else begin
      p = 0;
      for (int i = 0; i < 11; i++) if (r[i]) p = i;
      r = r << (10 - p);
      e = e - (10 - p);
    end
    rnd  = r[2] & (r[1] | r[0] | r[3]);
    mant = {1'b0, r[10:3]} + {8'd0, rnd};
    if (mant[8]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e <= 0)   return {big[15], 15'd0};
    if (e >= 255) return {big[15], 8'hFF, 7'd0};
    return {big[15], e[7:0], mant[6:0]};
  endfunction

  state_t                state;
  logic [TREE_LAT-1:0]   vld_sr, last_sr;
  logic [DATA_WIDTH-1:0] acc;
  logic [CHUNK_W-1:0]    cnt;
  logic                  first;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] data_mem  [FIFO_DEPTH];
  logic [CHUNK_W-1:0]    chunk_mem [FIFO_DEPTH];

  logic                  accept, tail_v, tail_l, push, pop;
  logic [LW-1:0]         lasts_in_flight;
  logic [DATA_WIDTH-1:0] sum_next;
  logic [CHUNK_W-1:0]    cnt_next;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i < TREE_LAT; i++) lasts_in_flight += LW'(last_sr[i]);
  end

  // Credit counts results already queued plus every last still inside the tree, so a push never finds the FIFO full.
  assign in_ready = rst_n & ~clear &
                    ((SW'(fifo_count) + SW'(lasts_in_flight)) < SW'(FIFO_DEPTH));
  assign accept   = in_valid & in_ready;
  assign tail_v   = vld_sr[TREE_LAT-1];
  assign tail_l   = last_sr[TREE_LAT-1];
  assign push     = tail_v & tail_l;
  assign pop      = out_ready & (fifo_count != '0);
  assign sum_next = first ? tree_sum : DATA_WIDTH'(bf16_add(16'(acc), 16'(tree_sum)));
  assign cnt_next = first ? CHUNK_W'(1) : ((&cnt) ? cnt : cnt + CHUNK_W'(1));

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? data_mem[rd_ptr]  : '0;
  assign out_chunks = out_valid ? chunk_mem[rd_ptr] : '0;
  assign busy       = (|vld_sr) | ~first | out_valid;

  // NOTE: all state here updates with <= so every read sees the value from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vld_sr     <= '0;
      last_sr    <= '0;
      acc        <= '0;
      cnt        <= '0;
      first      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      state      <= FLUSH;
      vld_sr     <= '0;
      last_sr    <= '0;
      acc        <= '0;
      cnt        <= '0;
      first      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      vld_sr  <= {vld_sr[TREE_LAT-2:0], accept};
      last_sr <= {last_sr[TREE_LAT-2:0], accept & in_last};
      if (push) begin
        acc   <= '0;
        cnt   <= '0;
        first <= 1'b1;
      end else if (tail_v) begin
        acc   <= sum_next;
        cnt   <= cnt_next;
        first <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      case (state)
        IDLE:    if (accept) state <= ACCUM;
        ACCUM:   if (push && vld_sr[TREE_LAT-2:0] == '0 && !accept) state <= IDLE;
        FLUSH:   state <= accept ? ACCUM : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the result storage has no reset; fifo_count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      data_mem[wr_ptr]  <= sum_next;
      chunk_mem[wr_ptr] <= cnt_next;
    end
  end

`ifdef TREE_ACC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_dots   <= '0;
      stat_stalls <= '0;
    end else if (clear) begin
      stat_dots   <= '0;
      stat_stalls <= '0;
    end else begin
      if (push)                  stat_dots   <= stat_dots + 32'd1;
      if (in_valid && !in_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tree_accum_ctrl.sv
// Bench for tree_accum_ctrl: a stand-in 8-stage adder tree, a queue-based reference model checked
// every cycle, and directed scenarios with hand-computed bf16 results.
module tb_tree_accum_ctrl;
  localparam int DW = 16, TL = 8, CHW = 8, FD = 4;

  logic           clk = 1'b0;
  logic           rst_n, clear, in_valid, in_last, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0]  tree_sum, out_data, lane_val;
  logic [CHW-1:0] out_chunks;
`ifdef TREE_ACC_STATS_EN
  logic [31:0]    stat_dots, stat_stalls;
`endif

  tree_accum_ctrl #(.DATA_WIDTH(DW), .TREE_LAT(TL), .CHUNK_W(CHW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chunks(out_chunks), .busy(busy)
`ifdef TREE_ACC_STATS_EN
    , .stat_dots(stat_dots), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real bf2r(input logic [15:0] b);
    logic [63:0] bits;
    int          ex;
    if (b[14:7] == 8'd0) return 0.0;
    ex   = int'(b[14:7]) - 127 + 1023;
    bits = {b[15], ex[10:0], b[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] bits;
    int          ex;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    ex   = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], ex[7:0], bits[51:45]};
  endfunction

  // Stand-in for the real tree: 128 identical lanes, eight register stages, no stall.
  logic [DW-1:0] tree_pipe [TL];
  always @(posedge clk) begin
    tree_pipe[0] <= r2bf(128.0 * bf2r(lane_val));
    for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_sum = tree_pipe[TL-1];

  // Reference model: beats wait in a queue until their tree sum is due, results queue in order.
  typedef struct { int due; logic [15:0] val; bit last; } beat_t;
  typedef struct { logic [15:0] d; int n; } res_t;
  beat_t pend[$];
  res_t  res[$];
  beat_t b_new, b_tail;
  res_t  r_new;
  real   partial = 0.0;
  int    nbeats = 0, lasts = 0, m_dots = 0, m_stalls = 0;
  bit    exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete(); res.delete();
      partial = 0.0; nbeats = 0; m_dots = 0; m_stalls = 0;
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_busy", 32'(busy), 0);
    end else begin
      lasts = 0;
      foreach (pend[i]) if (pend[i].last) lasts++;
      exp_rdy = !clear && (res.size() + lasts < FD);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(res.size() != 0));
      check("out_data", 32'(out_data), (res.size() != 0) ? 32'(res[0].d) : 32'd0);
      check("out_chunks", 32'(out_chunks), (res.size() != 0) ? 32'(res[0].n) : 32'd0);
      check("busy", 32'(busy), 32'(pend.size() != 0 || nbeats != 0 || res.size() != 0));
`ifdef TREE_ACC_STATS_EN
      check("stat_dots", stat_dots, 32'(m_dots));
      check("stat_stalls", stat_stalls, 32'(m_stalls));
`endif
      if (clear) begin
        pend.delete(); res.delete();
        partial = 0.0; nbeats = 0; m_dots = 0; m_stalls = 0;
      end else begin
        if (in_valid && !exp_rdy) m_stalls++;
        if (out_ready && res.size() != 0) void'(res.pop_front());
        if (pend.size() != 0 && pend[0].due == cyc) begin
          b_tail  = pend.pop_front();
          partial = partial + bf2r(b_tail.val);
          nbeats++;
          if (b_tail.last) begin
            if (res.size() >= FD) check("fifo_overflow", 32'(res.size()), FD - 1);
            r_new.d = r2bf(partial);
            r_new.n = (nbeats > 255) ? 255 : nbeats;
            res.push_back(r_new);
            partial = 0.0; nbeats = 0; m_dots++;
          end
        end
        if (in_valid && exp_rdy) begin
          b_new.due  = cyc + TL;
          b_new.val  = r2bf(128.0 * bf2r(lane_val));
          b_new.last = in_last;
          pend.push_back(b_new);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; lane_val = 16'h0000;
  endtask

  // Holds the beat on the bus until accepted; returns the accept cycle. Leaves in_valid high.
  task automatic send(input logic [15:0] lane, input logic last, output int acc_cyc);
    bit got = 1'b0;
    in_valid = 1'b1; in_last = last; lane_val = lane; acc_cyc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      acc_cyc = cyc;
      next_cycle();
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(input int budget);
    bit got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) check("out_valid_timeout", 0, 1);
  endtask

  int t, tb2, tc, t0, pop0, got3;
  int acc3 [6];
  logic [15:0] lanes3 [6];
  logic [15:0] want3  [6];
  logic [15:0] seen3  [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1; idle_in();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) next_cycle();

    // 1) single-beat dot of 128 x 1.0: out_valid 9 cycles after the accept
    send(16'h3F80, 1'b1, t); idle_in();
    wait_out(30);
    check("t1_latency", cyc - t, 9);
    check("t1_data", 32'(out_data), 32'h4300);
    check("t1_chunks", 32'(out_chunks), 1);
    repeat (4) next_cycle();

    // 2) three back-to-back beats of 1.0, last on the third: 384.0
    send(16'h3F80, 1'b0, t); send(16'h3F80, 1'b0, t); send(16'h3F80, 1'b1, t); idle_in();
    wait_out(30);
    check("t2_data", 32'(out_data), 32'h43C0);
    check("t2_chunks", 32'(out_chunks), 3);
    @(negedge clk);
    check("t2_busy_after_pop", 32'(busy), 0);
    repeat (4) next_cycle();

    // 3) consumer stalled, six single-beat dots offered: credit stops the fifth
    lanes3 = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4040, 16'h3FC0, 16'h4080};
    want3  = '{16'h4300, 16'h4380, 16'h4280, 16'h43C0, 16'h4340, 16'h4400};
    out_ready = 1'b0; t0 = cyc; got3 = 0; pop0 = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(lanes3[i], 1'b1, acc3[i]);
        idle_in();
      end
      begin
        wait_until(t0 + 20);
        out_ready = 1'b1;
        for (int k = 0; k < 300 && got3 < 6; k++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (got3 == 0) pop0 = cyc;
            seen3[got3] = out_data;
            got3++;
          end
        end
        if (got3 < 6) check("t3_drain_timeout", 32'(got3), 6);
      end
    join
    next_cycle();
    check("t3_four_back_to_back", acc3[3] - acc3[0], 3);
    check("t3_fifth_after_pop", acc3[4] - pop0, 1);
    for (int i = 0; i < 6; i++) check($sformatf("t3_order_%0d", i), 32'(seen3[i]), 32'(want3[i]));
    repeat (4) next_cycle();

    // 4) clear with a partial sum held and two beats in flight
    send(16'h3F80, 1'b0, t); idle_in();
    wait_until(t + 9);
    send(16'h3F80, 1'b0, tb2); send(16'h3F80, 1'b0, tb2); idle_in();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    check("t4_out_valid", 32'(out_valid), 0);
    check("t4_busy", 32'(busy), 0);
    repeat (15) next_cycle();
    send(16'h4000, 1'b1, t); idle_in();
    wait_out(30);
    check("t4_data", 32'(out_data), 32'h4380);
    check("t4_chunks", 32'(out_chunks), 1);
    repeat (4) next_cycle();

    // 5) asynchronous reset mid-accumulation
    send(16'h3F80, 1'b0, t); send(16'h3F80, 1'b0, tc); idle_in();
    wait_until(t + 9);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_out_valid", 32'(out_valid), 0);
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_in_ready", 32'(in_ready), 0);
    check("t5_async_out_data", 32'(out_data), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) next_cycle();
    check("t5_busy_idle", 32'(busy), 0);
    send(16'h3F80, 1'b1, t); idle_in();
    wait_out(30);
    check("t5_data", 32'(out_data), 32'h4300);
    check("t5_chunks", 32'(out_chunks), 1);
    repeat (4) next_cycle();

    // 6) push and pop in the same cycle with two results queued
    out_ready = 1'b0;
    send(16'h3F00, 1'b1, t); send(16'h3F80, 1'b1, tc); send(16'h4000, 1'b1, tc); idle_in();
    wait_until(t + 10);
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("t6_valid_after_swap", 32'(out_valid), 1);
    check("t6_head_after_swap", 32'(out_data), 32'h4300);
    check("t6_ready_count2", 32'(in_ready), 1);
    next_cycle();
    out_ready = 1'b1;
    wait_out(10);
    check("t6_second", 32'(out_data), 32'h4300);
    @(negedge clk);
    check("t6_third", 32'(out_data), 32'h4380);
    repeat (4) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
